deser_framer: RTL
=================

DESER_FRAMER -- requirements
Module: deser_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning output word width in bits (legal range 2..64).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 puts the first received bit of a word in word_out[WIDTH-1] and 0 puts it in word_out[0].
REQ-003 SHALL have parameter SYNC_WORD, default 16'hA5A5 (WIDTH bits), meaning the alignment pattern searched for in HUNT.
REQ-004 SHALL have port clk, input, 1, system clock, all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port bit_in, input, 1, serial data bit.
REQ-007 SHALL have port bit_valid, input, 1, bit_in is sampled only when this is 1.
REQ-008 SHALL have port sync_en, input, 1, where 1 means framing waits for SYNC_WORD and 0 means free-run framing from the first valid bit.
REQ-009 SHALL have port resync, input, 1, single-cycle pulse that forces a return to HUNT.
REQ-010 SHALL have port word_ready, input, 1, consumer accepts word_out when word_valid is also 1.
REQ-011 SHALL have port ovf_clr, input, 1, clears overflow.
REQ-012 SHALL have port word_out, output, WIDTH, assembled word.
REQ-013 SHALL have port word_valid, output, 1, word_out holds an unconsumed word.
REQ-014 SHALL have port locked, output, 1, state is LOCKED.
REQ-015 SHALL have port overflow, output, 1, sticky flag set when a completed word was dropped.

Function
REQ-016 SHALL implement states HUNT and LOCKED, with locked=1 exactly when the state is LOCKED.
REQ-017 SHALL leave all state, shift register and counters unchanged on cycles with bit_valid=0, except for handshake, resync and ovf_clr effects.
REQ-018 SHALL use a WIDTH-bit shift register as follows: with MSB_FIRST=1, shreg <= {shreg[WIDTH-2:0], bit_in}; with MSB_FIRST=0, shreg <= {bit_in, shreg[WIDTH-1:1]}.
REQ-019 SHALL, in HUNT, count valid bits with a fill counter saturating at WIDTH; a match is declared only when the fill counter is at WIDTH and the next shreg value equals SYNC_WORD.
REQ-020 SHALL, on a HUNT match, go to LOCKED with bit counter = 0; the sync word itself is never emitted.
REQ-021 SHALL, in HUNT with sync_en=0, go to LOCKED on the next clock edge without consuming a bit, with bit counter = 0.
REQ-022 SHALL, in LOCKED, increment a $clog2(WIDTH)-bit counter on each valid bit; on the WIDTH-th valid bit (counter = WIDTH-1) the word completes and the counter wraps to 0.
REQ-023 SHALL, on word completion, load word_out with the next shreg value (including the current bit) and set word_valid on the same edge, giving 1-cycle latency from the last bit sample to word_valid visible.
REQ-024 SHALL clear word_valid on an edge where word_valid=1 and word_ready=1, unless a new word completes on that edge.
REQ-025 SHALL, when a word completes with word_valid=1 and word_ready=0, keep word_out and word_valid unchanged, drop the new word and set overflow=1.
REQ-026 SHALL, when a word completes with word_valid=1 and word_ready=1, load the new word, keep word_valid=1 and leave overflow unchanged.
REQ-027 SHALL make word_out change only on word completion.
REQ-028 SHALL, on resync=1, enter HUNT with fill counter and bit counter = 0 and ignore that cycle's bit; word_valid, word_out and overflow are unaffected.
REQ-029 SHALL give resync priority over word completion in the same cycle, with no word emitted.
REQ-030 SHALL clear overflow on ovf_clr=1, except that a simultaneous overflow event sets it (set wins).
REQ-031 SHALL treat a change in sync_en as taking effect only in HUNT, with no effect while LOCKED.

Reset
REQ-032 SHALL, on reset=1, asynchronously set the state to HUNT, shreg/fill counter/bit counter = 0, word_out = 0, word_valid = 0, overflow = 0 and locked = 0.
REQ-033 SHALL, on reset asserted mid-word, discard the partial word, with the first word after reset requiring the full WIDTH bits (plus sync when sync_en=1).

Verification
REQ-034 SHALL cover: WIDTH=16, sync_en=0, word_ready=1, 16 valid bits of 0x1234 MSB-first -> word_out=0x1234, word_valid pulses 1 cycle, locked=1.
REQ-035 SHALL cover: sync_en=1, stream 0xA5A5 then 0xBEEF -> no word emitted for 0xA5A5, word_out=0xBEEF, and the 15 bits preceding a full fill never match.
REQ-036 SHALL cover: MSB_FIRST=0, bits 1,0,0,...,0 -> word_out=0x0001.
REQ-037 SHALL cover: word_ready=0, two complete words 0x1111 then 0x2222 -> word_out stays 0x1111 and overflow=1; then ovf_clr -> overflow=0.
REQ-038 SHALL cover: bit_valid toggled 1/0 every cycle -> same words as the continuous case; resync after 7 bits -> locked=0 and no word until sync is found again.
REQ-039 SHALL cover: reset after 10 bits of a word -> all outputs 0, and the next word needs a full 16 bits.

Source files
------------

// File: rtl/deser_framer.sv
// rtl/deser_framer.sv - serial-to-parallel deframer with sync-word hunt and word handshake
// HUNT searches for SYNC_WORD (or locks at once when sync_en=0); LOCKED emits WIDTH-bit words.
module deser_framer #(
  parameter int              WIDTH     = 16,
  parameter bit              MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(16'hA5A5)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sync_en,
  input  logic             resync,
  input  logic             word_ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             locked,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam int FW = $clog2(WIDTH + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shreg_shift;
  logic [FW-1:0]    fill, fill_nxt, fill_inc;
  logic [CW-1:0]    bcnt, bcnt_nxt;
  logic [WIDTH-1:0] word_nxt;
  logic             valid_nxt, ovf_nxt;
  logic             complete, load, ovf_event;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      shreg      <= '0;
      fill       <= '0;
      bcnt       <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      fill       <= fill_nxt;
      bcnt       <= bcnt_nxt;
      word_out   <= word_nxt;
      word_valid <= valid_nxt;
      overflow   <= ovf_nxt;
    end
  end

  always_comb begin
    shreg_shift = MSB_FIRST ? {shreg[WIDTH-2:0], bit_in} : {bit_in, shreg[WIDTH-1:1]};
    fill_inc    = (fill == FW'(WIDTH)) ? fill : fill + 1'b1;

    state_nxt = state;
    shreg_nxt = shreg;
    fill_nxt  = fill;
    bcnt_nxt  = bcnt;
    complete  = 1'b0;

    // resync wins over everything, including a word completing this cycle
    if (resync) begin
      state_nxt = HUNT;
      fill_nxt  = '0;
      bcnt_nxt  = '0;
    end else begin
      case (state)
        HUNT: begin
          if (!sync_en) begin
            state_nxt = LOCKED;
            bcnt_nxt  = '0;
          end else if (bit_valid) begin
            shreg_nxt = shreg_shift;
            fill_nxt  = fill_inc;
            if (fill_inc == FW'(WIDTH) && shreg_shift == SYNC_WORD) begin
              state_nxt = LOCKED;
              bcnt_nxt  = '0;
            end
          end
        end
        LOCKED: begin
          if (bit_valid) begin
            shreg_nxt = shreg_shift;
            if (bcnt == CW'(WIDTH - 1)) begin
              bcnt_nxt = '0;
              complete = 1'b1;
            end else begin
              bcnt_nxt = bcnt + 1'b1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    // a stalled consumer keeps the old word; the new one is dropped and flagged
    ovf_event = complete && word_valid && !word_ready;
    load      = complete && !ovf_event;

    word_nxt  = load ? shreg_shift : word_out;
    valid_nxt = word_valid;
    if (load)
      valid_nxt = 1'b1;
    else if (word_valid && word_ready)
      valid_nxt = 1'b0;

    ovf_nxt = overflow;
    if (ovf_event)
      ovf_nxt = 1'b1;
    else if (ovf_clr)
      ovf_nxt = 1'b0;
  end

  assign locked = (state == LOCKED);

endmodule
